// File: rtl/gtxe2_chnl_tx_oob_multi_pkg.sv
// Shared definitions for the multi-lane TX OOB sequencer.
// Holds the per-lane FSM state encoding, the latched sequence type codes and
// a small helper used to size the per-lane cycle counter.
package gtxe2_chnl_tx_oob_multi_pkg;

  typedef enum logic [2:0] {
    OobIdle  = 3'd0,
    OobBurst = 3'd1,
    OobGap   = 3'd2,
    OobDone  = 3'd3,
    OobAbort = 3'd4
  } oob_state_e;

  typedef enum logic [1:0] {
    OobTInit = 2'd0,
    OobTWake = 2'd1,
    OobTSas  = 2'd2
  } oob_type_e;

  function automatic int unsigned max4(int unsigned a, int unsigned b, int unsigned c,
                                       int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/gtxe2_chnl_tx_oob_multi_if.sv
// Request/status bundle between the user TXCOM* logic and the OOB sequencer.
//   master : drives TXCOMINIT/TXCOMWAKE/TXCOMSAS/TXELECIDLE, reads status
//   slave  : the sequencer; reads requests, drives tx_burst/TXCOMFINISH/oob_busy/oob_abort
interface gtxe2_chnl_tx_oob_multi_if #(
  parameter int unsigned NUM_LANES = 4
);
  logic [NUM_LANES-1:0] TXCOMINIT;
  logic [NUM_LANES-1:0] TXCOMWAKE;
  logic [NUM_LANES-1:0] TXCOMSAS;
  logic [NUM_LANES-1:0] TXELECIDLE;
  logic [NUM_LANES-1:0] tx_burst;
  logic [NUM_LANES-1:0] TXCOMFINISH;
  logic [NUM_LANES-1:0] oob_busy;
  logic [NUM_LANES-1:0] oob_abort;

  modport master (
    output TXCOMINIT, TXCOMWAKE, TXCOMSAS, TXELECIDLE,
    input  tx_burst, TXCOMFINISH, oob_busy, oob_abort
  );

  modport slave (
    input  TXCOMINIT, TXCOMWAKE, TXCOMSAS, TXELECIDLE,
    output tx_burst, TXCOMFINISH, oob_busy, oob_abort
  );
endinterface

// File: rtl/gtxe2_chnl_tx_oob_multi_lane.sv
// Single-lane OOB burst sequencer: IDLE -> BURST -> GAP -> (BURST | DONE) -> IDLE,
// with ABORT when electrical idle drops mid-sequence.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_init_i/_wake_i/_sas_i  sequence requests (level-sampled in IDLE)
//   start_ok_i            electrical-idle qualifier used to accept a request
//   elec_idle_i           this lane's electrical idle; low in BURST/GAP aborts
//   tx_burst_o            burst gate, registered
//   finish_o, abort_o     one-cycle completion / abort pulses, registered
//   busy_o                high whenever the lane is not IDLE, registered
module gtxe2_chnl_tx_oob_multi_lane
  import gtxe2_chnl_tx_oob_multi_pkg::*;
#(
  parameter logic [3:0]  SATA_BURST_SEQ_LEN = 4'd6,
  parameter int unsigned BURST_CYCLES       = 4,
  parameter int unsigned INIT_IDLE_CYCLES   = 12,
  parameter int unsigned WAKE_IDLE_CYCLES   = 4,
  parameter int unsigned SAS_IDLE_CYCLES    = 36
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_init_i,
  input  logic req_wake_i,
  input  logic req_sas_i,
  input  logic start_ok_i,
  input  logic elec_idle_i,
  output logic tx_burst_o,
  output logic finish_o,
  output logic busy_o,
  output logic abort_o
);

  localparam int unsigned CW = $clog2(max4(BURST_CYCLES, INIT_IDLE_CYCLES, WAKE_IDLE_CYCLES,
                                           SAS_IDLE_CYCLES) + 1);
  localparam logic [3:0]  SeqEff = (SATA_BURST_SEQ_LEN == 4'd0) ? 4'd1 : SATA_BURST_SEQ_LEN;

  oob_state_e    state_q, state_d;
  oob_type_e     type_q, type_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bursts_q, bursts_d;  // bursts still to emit, including the current one

  function automatic logic [CW-1:0] gap_len(oob_type_e t);
    case (t)
      OobTWake: return CW'(WAKE_IDLE_CYCLES);
      OobTSas:  return CW'(SAS_IDLE_CYCLES);
      default:  return CW'(INIT_IDLE_CYCLES);
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    cnt_d    = cnt_q;
    bursts_d = bursts_q;
    unique case (state_q)
      OobIdle: begin
        if (start_ok_i && (req_init_i || req_wake_i || req_sas_i)) begin
          type_d   = req_init_i ? OobTInit : (req_wake_i ? OobTWake : OobTSas);
          state_d  = OobBurst;
          cnt_d    = CW'(BURST_CYCLES);
          bursts_d = SeqEff;
        end
      end
      OobBurst: begin
        if (!elec_idle_i) begin
          state_d = OobAbort;
        end else if (cnt_q == CW'(1)) begin
          state_d = OobGap;
          cnt_d   = gap_len(type_q);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      OobGap: begin
        if (!elec_idle_i) begin
          state_d = OobAbort;
        end else if (cnt_q == CW'(1)) begin
          if (bursts_q == 4'd1) begin
            state_d = OobDone;
          end else begin
            state_d  = OobBurst;
            cnt_d    = CW'(BURST_CYCLES);
            bursts_d = bursts_q - 4'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      OobDone, OobAbort: state_d = OobIdle;
      default:           state_d = OobIdle;
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= OobIdle;
      type_q     <= OobTInit;
      cnt_q      <= '0;
      bursts_q   <= '0;
      tx_burst_o <= 1'b0;
      finish_o   <= 1'b0;
      busy_o     <= 1'b0;
      abort_o    <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      cnt_q      <= cnt_d;
      bursts_q   <= bursts_d;
      tx_burst_o <= (state_d == OobBurst);
      finish_o   <= (state_d == OobDone);
      busy_o     <= (state_d != OobIdle);
      abort_o    <= (state_d == OobAbort);
    end
  end

endmodule

// File: rtl/gtxe2_chnl_tx_oob_multi.sv
// Multi-lane SATA/SAS OOB burst sequencer for the GTXE2 channel model.
// One independent sequencer per lane; with GANGED set, lane 0's requests and
// electrical-idle qualifier start every lane, while each lane keeps its own abort.
// Ports:
//   TXUSRCLK2  sole clock (rising edge)
//   reset      synchronous, active-high
//   bus        slave side of the request/status interface (NUM_LANES wide)
module gtxe2_chnl_tx_oob_multi
  import gtxe2_chnl_tx_oob_multi_pkg::*;
#(
  parameter int unsigned NUM_LANES          = 4,
  parameter logic [3:0]  SATA_BURST_SEQ_LEN = 4'd6,
  parameter int unsigned BURST_CYCLES       = 4,
  parameter int unsigned INIT_IDLE_CYCLES   = 12,
  parameter int unsigned WAKE_IDLE_CYCLES   = 4,
  parameter int unsigned SAS_IDLE_CYCLES    = 36,
  parameter bit          GANGED             = 1'b0
) (
  input logic                           TXUSRCLK2,
  input logic                           reset,
  gtxe2_chnl_tx_oob_multi_if.slave      bus
);

  logic [NUM_LANES-1:0] burst_w, finish_w, busy_w, abort_w;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam int Src = GANGED ? 0 : i;

    gtxe2_chnl_tx_oob_multi_lane #(
      .SATA_BURST_SEQ_LEN (SATA_BURST_SEQ_LEN),
      .BURST_CYCLES       (BURST_CYCLES),
      .INIT_IDLE_CYCLES   (INIT_IDLE_CYCLES),
      .WAKE_IDLE_CYCLES   (WAKE_IDLE_CYCLES),
      .SAS_IDLE_CYCLES    (SAS_IDLE_CYCLES)
    ) u_lane (
      .clk_i       (TXUSRCLK2),
      .rst_i       (reset),
      .req_init_i  (bus.TXCOMINIT[Src]),
      .req_wake_i  (bus.TXCOMWAKE[Src]),
      .req_sas_i   (bus.TXCOMSAS[Src]),
      .start_ok_i  (bus.TXELECIDLE[Src]),
      .elec_idle_i (bus.TXELECIDLE[i]),
      .tx_burst_o  (burst_w[i]),
      .finish_o    (finish_w[i]),
      .busy_o      (busy_w[i]),
      .abort_o     (abort_w[i])
    );
  end

  assign bus.tx_burst    = burst_w;
  assign bus.TXCOMFINISH = finish_w;
  assign bus.oob_busy    = busy_w;
  assign bus.oob_abort   = abort_w;

endmodule

// File: tb/tb_gtxe2_chnl_tx_oob_multi.sv
// Bench for the OOB sequencer: three instances (default, ganged, SEQ_LEN=0) share
// the same stimulus. Expected outputs come from a per-lane model that tracks the
// offset into the sequence and derives burst/gap/finish arithmetically.
module tb_gtxe2_chnl_tx_oob_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] init_v, wake_v, sas_v, eidle_v;

  always #5 clk = ~clk;

  gtxe2_chnl_tx_oob_multi_if #(.NUM_LANES(4)) bus_a ();
  gtxe2_chnl_tx_oob_multi_if #(.NUM_LANES(4)) bus_g ();
  gtxe2_chnl_tx_oob_multi_if #(.NUM_LANES(4)) bus_z ();

  assign bus_a.TXCOMINIT = init_v;  assign bus_a.TXCOMWAKE = wake_v;
  assign bus_a.TXCOMSAS  = sas_v;   assign bus_a.TXELECIDLE = eidle_v;
  assign bus_g.TXCOMINIT = init_v;  assign bus_g.TXCOMWAKE = wake_v;
  assign bus_g.TXCOMSAS  = sas_v;   assign bus_g.TXELECIDLE = eidle_v;
  assign bus_z.TXCOMINIT = init_v;  assign bus_z.TXCOMWAKE = wake_v;
  assign bus_z.TXCOMSAS  = sas_v;   assign bus_z.TXELECIDLE = eidle_v;

  gtxe2_chnl_tx_oob_multi #(.GANGED(1'b0)) dut_a (.TXUSRCLK2(clk), .reset(rst), .bus(bus_a));
  gtxe2_chnl_tx_oob_multi #(.GANGED(1'b1)) dut_g (.TXUSRCLK2(clk), .reset(rst), .bus(bus_g));
  gtxe2_chnl_tx_oob_multi #(.SATA_BURST_SEQ_LEN(4'd0)) dut_z (
    .TXUSRCLK2(clk), .reset(rst), .bus(bus_z));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: mode 0 idle, 1 running (k = cycles since first burst cycle), 2 abort cycle.
  int         m_mode[3][4];
  int         m_k[3][4];
  int         m_typ[3][4];
  int         seqn[3] = '{6, 6, 1};
  bit         gang[3] = '{1'b0, 1'b1, 1'b0};
  logic [3:0] e_burst[3], e_fin[3], e_busy[3], e_abort[3];

  function automatic int gap_of(input int typ);
    return (typ == 0) ? 12 : ((typ == 1) ? 4 : 36);
  endfunction

  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      for (int l = 0; l < 4; l++) begin
        int src;
        int per;
        int tot;
        src = gang[d] ? 0 : l;
        if (rst) begin
          m_mode[d][l] = 0;
        end else if (m_mode[d][l] == 0) begin
          if (eidle_v[src] && (init_v[src] || wake_v[src] || sas_v[src])) begin
            m_mode[d][l] = 1;
            m_k[d][l]    = 0;
            m_typ[d][l]  = init_v[src] ? 0 : (wake_v[src] ? 1 : 2);
          end
        end else if (m_mode[d][l] == 1) begin
          tot = seqn[d] * (4 + gap_of(m_typ[d][l]));
          if (m_k[d][l] < tot && !eidle_v[l]) m_mode[d][l] = 2;
          else if (m_k[d][l] == tot)          m_mode[d][l] = 0;
          else                                m_k[d][l]++;
        end else begin
          m_mode[d][l] = 0;
        end
        per = 4 + gap_of(m_typ[d][l]);
        tot = seqn[d] * per;
        e_busy[d][l]  = (m_mode[d][l] != 0);
        e_abort[d][l] = (m_mode[d][l] == 2);
        e_fin[d][l]   = (m_mode[d][l] == 1) && (m_k[d][l] == tot);
        e_burst[d][l] = (m_mode[d][l] == 1) && (m_k[d][l] < tot) && ((m_k[d][l] % per) < 4);
      end
    end
  endtask

  int cyc = 0;
  int t0 = 0;
  bit rec = 1'b0;
  int fin_at[3][4];

  task automatic note_fin(input int d, input logic [3:0] f);
    for (int l = 0; l < 4; l++)
      if (f[l] === 1'b1 && fin_at[d][l] < 0) fin_at[d][l] = cyc - t0 + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    check("a tx_burst", 32'(bus_a.tx_burst), 32'(e_burst[0]));
    check("a finish",   32'(bus_a.TXCOMFINISH), 32'(e_fin[0]));
    check("a busy",     32'(bus_a.oob_busy), 32'(e_busy[0]));
    check("a abort",    32'(bus_a.oob_abort), 32'(e_abort[0]));
    check("g tx_burst", 32'(bus_g.tx_burst), 32'(e_burst[1]));
    check("g finish",   32'(bus_g.TXCOMFINISH), 32'(e_fin[1]));
    check("g busy",     32'(bus_g.oob_busy), 32'(e_busy[1]));
    check("g abort",    32'(bus_g.oob_abort), 32'(e_abort[1]));
    check("z tx_burst", 32'(bus_z.tx_burst), 32'(e_burst[2]));
    check("z finish",   32'(bus_z.TXCOMFINISH), 32'(e_fin[2]));
    check("z busy",     32'(bus_z.oob_busy), 32'(e_busy[2]));
    check("z abort",    32'(bus_z.oob_abort), 32'(e_abort[2]));
    if (rec) begin
      note_fin(0, bus_a.TXCOMFINISH);
      note_fin(1, bus_g.TXCOMFINISH);
      note_fin(2, bus_z.TXCOMFINISH);
    end
  endtask

  int exp_fin[3][4] = '{'{97, 49, 241, -1}, '{97, 97, 97, 97}, '{17, 9, 41, -1}};

  initial begin
    rst     = 1'b1;
    init_v  = '0;
    wake_v  = '0;
    sas_v   = '0;
    eidle_v = 4'hf;
    for (int d = 0; d < 3; d++)
      for (int l = 0; l < 4; l++) fin_at[d][l] = -1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Directed: INIT on lane 0, WAKE on lane 1, SAS on lane 2 in the same cycle.
    init_v = 4'b0001;
    wake_v = 4'b0010;
    sas_v  = 4'b0100;
    t0     = cyc + 1;
    rec    = 1'b1;
    tick();
    init_v = '0;
    wake_v = '0;
    sas_v  = '0;
    for (int i = 0; i < 260; i++) begin
      if (i == 40) wake_v = 4'b0001;  // mid-sequence request must be ignored
      if (i == 41) wake_v = '0;
      tick();
    end
    rec = 1'b0;
    for (int d = 0; d < 3; d++)
      for (int l = 0; l < 4; l++)
        check($sformatf("finish offset dut%0d lane%0d", d, l), 32'(fin_at[d][l]),
              32'(exp_fin[d][l]));

    // Random requests, electrical-idle drops and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(499) == 0);
      for (int l = 0; l < 4; l++) begin
        init_v[l]  = ($urandom_range(29) == 0);
        wake_v[l]  = ($urandom_range(19) == 0);
        sas_v[l]   = ($urandom_range(19) == 0);
        eidle_v[l] = ($urandom_range(59) != 0);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
